// File: rtl/rate_lock_sequencer.sv
// rtl/rate_lock_sequencer.sv - rate-recovery acquire/track/relock sequencer
//
// Ports:
//   sys_dom_i       clock/reset bundle (single clock, synchronous active-high reset)
//   enable_i        run sequencer; low forces IDLE
//   rate_min_i      full-rate band lower bound (inclusive)
//   rate_max_i      full-rate band upper bound (inclusive)
//   miss_limit_i    consecutive out-of-band samples in TRACK before relock; 0 = never
//   timeout_i       cycles with no sample before relock; 0 = never
//   sample_valid_i  one-cycle strobe, new interval measured
//   sample_i        measured interval
//   prio_locked_i   prioritizer lock indication
//   prio_rate_i     prioritizer winning value
//   prio_clear_o    prioritizer state clear
//   prio_we_o       prioritizer write enable
//   prio_data_o     prioritizer write data (folded sample)
//   state_o         IDLE=0, CLEAR=1, ACQUIRE=2, TRACK=3
//   locked_o        rate valid and tracking
//   rate_o          recovered rate
//   relock_count_o  saturating count of TRACK->CLEAR relocks

package common_p;
  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;
endpackage

module rate_lock_sequencer #(
  parameter int RATE_W    = 16,
  parameter int MISS_W    = 4,
  parameter int TIMEOUT_W = 20
) (
  input  common_p::clk_dom_s   sys_dom_i,
  input  logic                 enable_i,
  input  logic [RATE_W-1:0]    rate_min_i,
  input  logic [RATE_W-1:0]    rate_max_i,
  input  logic [MISS_W-1:0]    miss_limit_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 sample_valid_i,
  input  logic [RATE_W-1:0]    sample_i,
  input  logic                 prio_locked_i,
  input  logic [RATE_W-1:0]    prio_rate_i,
  output logic                 prio_clear_o,
  output logic                 prio_we_o,
  output logic [RATE_W-1:0]    prio_data_o,
  output logic [1:0]           state_o,
  output logic                 locked_o,
  output logic [RATE_W-1:0]    rate_o,
  output logic [7:0]           relock_count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_ACQUIRE = 2'd2,
    S_TRACK   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    C_OUT    = 2'd0,
    C_FULL   = 2'd1,
    C_HALF   = 2'd2,
    C_DOUBLE = 2'd3
  } cls_e;

  localparam int XW = RATE_W + 1;
  localparam logic [TIMEOUT_W-1:0] TMO_ONE  = TIMEOUT_W'(1);
  localparam logic [MISS_W:0]      MISS_ONE = (MISS_W + 1)'(1);

  logic clk;
  logic rst;
  assign clk = sys_dom_i.clk;
  assign rst = sys_dom_i.rst;

  state_e state_q, state_d;

  logic [MISS_W-1:0]    miss_q, miss_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 accept;
  logic                 relock_inc;
  logic                 lock_d;

  // Classification. Everything is widened by one bit so 2*s never wraps
  // and a HALF candidate cannot alias into the band.
  logic [XW-1:0] lo_x, hi_x, s_full_x, s_half_x, s_dbl_x;
  logic          in_full, in_half, in_dbl;
  cls_e          cls;
  logic [RATE_W-1:0] folded;

  assign lo_x     = {1'b0, rate_min_i};
  assign hi_x     = {1'b0, rate_max_i};
  assign s_full_x = {1'b0, sample_i};
  assign s_half_x = {sample_i, 1'b0};
  assign s_dbl_x  = {2'b00, sample_i[RATE_W-1:1]};

  // An inverted band (min > max) leaves every range test false, so all
  // samples fall through to OUT without a dedicated check.
  assign in_full = (lo_x <= s_full_x) && (s_full_x <= hi_x);
  assign in_half = (lo_x <= s_half_x) && (s_half_x <= hi_x);
  assign in_dbl  = (lo_x <= s_dbl_x)  && (s_dbl_x  <= hi_x);

  always_comb begin
    cls    = C_OUT;
    folded = sample_i;
    if (in_full) begin
      cls    = C_FULL;
      folded = sample_i;
    end else if (in_half) begin
      cls    = C_HALF;
      folded = s_half_x[RATE_W-1:0];
    end else if (in_dbl) begin
      cls    = C_DOUBLE;
      folded = s_dbl_x[RATE_W-1:0];
    end
  end

  // Miss and timeout counters both saturate so they never wrap back
  // below their limits.
  logic [MISS_W:0]      miss_p1;
  logic [MISS_W-1:0]    miss_sat;
  logic                 miss_hit;
  logic [TIMEOUT_W-1:0] tmo_inc;
  logic                 tmo_hit;

  assign miss_p1  = {1'b0, miss_q} + MISS_ONE;
  assign miss_sat = (&miss_q) ? miss_q : miss_p1[MISS_W-1:0];
  assign miss_hit = (miss_limit_i != '0) && (miss_p1 == {1'b0, miss_limit_i});

  // Timeout fires on the edge where the counter would reach the limit.
  // A sample in that same cycle restarts the timer instead.
  assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + TMO_ONE;
  assign tmo_hit = (timeout_i != '0) && !sample_valid_i && (tmo_inc >= timeout_i);

  always_comb begin
    state_d    = state_q;
    miss_d     = miss_q;
    tmo_d      = tmo_q;
    accept     = 1'b0;
    relock_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        miss_d = '0;
        tmo_d  = '0;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        miss_d  = '0;
        tmo_d   = '0;
        state_d = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        tmo_d = sample_valid_i ? '0 : tmo_inc;
        if (tmo_hit) begin
          state_d = S_CLEAR;
        end else begin
          // Only exact full-rate samples seed the prioritizer while acquiring.
          accept = sample_valid_i && (cls == C_FULL);
          if (prio_locked_i) begin
            state_d = S_TRACK;
          end
        end
      end
      S_TRACK: begin
        tmo_d = sample_valid_i ? '0 : tmo_inc;
        if (tmo_hit) begin
          state_d    = S_CLEAR;
          relock_inc = 1'b1;
        end else if (sample_valid_i && (cls == C_OUT) && miss_hit) begin
          // The sample that exhausts the miss budget is dropped.
          state_d    = S_CLEAR;
          relock_inc = 1'b1;
        end else begin
          if (sample_valid_i) begin
            if (cls == C_OUT) begin
              miss_d = miss_sat;
            end else begin
              accept = 1'b1;
              miss_d = '0;
            end
          end
          if (!prio_locked_i) begin
            state_d = S_ACQUIRE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!enable_i) begin
      state_d    = S_IDLE;
      accept     = 1'b0;
      relock_inc = 1'b0;
    end
  end

  assign lock_d = (state_q == S_TRACK) && prio_locked_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      miss_q         <= '0;
      tmo_q          <= '0;
      prio_we_o      <= 1'b0;
      prio_data_o    <= '0;
      locked_o       <= 1'b0;
      rate_o         <= '0;
      relock_count_o <= '0;
    end else begin
      state_q   <= state_d;
      miss_q    <= miss_d;
      tmo_q     <= tmo_d;
      prio_we_o <= accept;
      if (accept) begin
        prio_data_o <= folded;
      end
      locked_o <= lock_d;
      if (lock_d) begin
        rate_o <= prio_rate_i;
      end
      if (relock_inc && (relock_count_o != 8'hFF)) begin
        relock_count_o <= relock_count_o + 8'd1;
      end
    end
  end

  // Clear is asserted straight from reset so the prioritizer is held
  // cleared before the state register has been initialised.
  assign prio_clear_o = rst || (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign state_o      = state_q;

endmodule

// File: tb/tb_rate_lock_sequencer.sv
// tb/tb_rate_lock_sequencer.sv - directed self-checking bench for rate_lock_sequencer

module tb_rate_lock_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] rate_min;
  logic [15:0] rate_max;
  logic [3:0]  miss_limit;
  logic [19:0] timeout;
  logic        sample_valid;
  logic [15:0] sample;
  logic        prio_locked;
  logic [15:0] prio_rate;
  logic        prio_clear;
  logic        prio_we;
  logic [15:0] prio_data;
  logic [1:0]  state;
  logic        locked;
  logic [15:0] rate;
  logic [7:0]  relock_count;

  common_p::clk_dom_s sys_dom;
  assign sys_dom = '{clk: clk, rst: rst};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rate_lock_sequencer #(
    .RATE_W    (16),
    .MISS_W    (4),
    .TIMEOUT_W (20)
  ) dut (
    .sys_dom_i      (sys_dom),
    .enable_i       (enable),
    .rate_min_i     (rate_min),
    .rate_max_i     (rate_max),
    .miss_limit_i   (miss_limit),
    .timeout_i      (timeout),
    .sample_valid_i (sample_valid),
    .sample_i       (sample),
    .prio_locked_i  (prio_locked),
    .prio_rate_i    (prio_rate),
    .prio_clear_o   (prio_clear),
    .prio_we_o      (prio_we),
    .prio_data_o    (prio_data),
    .state_o        (state),
    .locked_o       (locked),
    .rate_o         (rate),
    .relock_count_o (relock_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle sample strobe, then check the registered write path.
  task automatic send(input string tag, input logic [15:0] v,
                      input logic exp_we, input logic [15:0] exp_data);
    sample_valid = 1'b1;
    sample       = v;
    tick();
    sample_valid = 1'b0;
    chk({tag, "_we"}, 32'(prio_we), 32'(exp_we));
    chk({tag, "_data"}, 32'(prio_data), 32'(exp_data));
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    rate_min     = 16'd90;
    rate_max     = 16'd110;
    miss_limit   = 4'd0;
    timeout      = 20'd0;
    sample_valid = 1'b0;
    sample       = 16'd0;
    prio_locked  = 1'b0;
    prio_rate    = 16'd0;

    #1;
    chk("clear_in_reset", 32'(prio_clear), 32'd1);
    ticks(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_we", 32'(prio_we), 32'd0);
    chk("rst_data", 32'(prio_data), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_rate", 32'(rate), 32'd0);
    chk("rst_relock", 32'(relock_count), 32'd0);

    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(state), 32'd0);
    enable = 1'b1;
    tick();
    chk("st_clear", 32'(state), 32'd1);
    chk("clear_hi", 32'(prio_clear), 32'd1);
    tick();
    chk("st_acq", 32'(state), 32'd2);
    chk("clear_lo", 32'(prio_clear), 32'd0);

    // Acquire: full-rate samples written, folded candidates ignored.
    for (int i = 0; i < 4; i++) begin
      send("acq_full", 16'd100, 1'b1, 16'd100);
      tick();
      chk("acq_we_pulse", 32'(prio_we), 32'd0);
    end
    send("acq_half", 16'd50, 1'b0, 16'd100);
    send("acq_dbl", 16'd200, 1'b0, 16'd100);
    send("acq_out", 16'd300, 1'b0, 16'd100);
    rate_min = 16'd110;
    rate_max = 16'd90;
    send("acq_inv_band", 16'd100, 1'b0, 16'd100);
    rate_min = 16'd90;
    rate_max = 16'd110;

    prio_locked = 1'b1;
    prio_rate   = 16'd100;
    tick();
    chk("st_track", 32'(state), 32'd3);
    chk("locked_lag", 32'(locked), 32'd0);
    tick();
    chk("locked_on", 32'(locked), 32'd1);
    chk("rate_100", 32'(rate), 32'd100);
    prio_rate = 16'd101;
    tick();
    chk("rate_101", 32'(rate), 32'd101);

    // Folding in TRACK.
    send("trk_half", 16'd50, 1'b1, 16'd100);
    send("trk_dbl", 16'd200, 1'b1, 16'd100);
    send("trk_dbl_odd", 16'd201, 1'b1, 16'd100);
    send("trk_half_edge", 16'd55, 1'b1, 16'd110);
    send("trk_full_max", 16'd110, 1'b1, 16'd110);
    send("trk_out_hi", 16'd111, 1'b0, 16'd110);
    send("trk_out_lo", 16'd89, 1'b0, 16'd110);
    send("trk_full_min", 16'd90, 1'b1, 16'd90);

    // Miss relock after three consecutive OUT samples.
    miss_limit = 4'd3;
    send("miss1", 16'd300, 1'b0, 16'd90);
    chk("miss1_st", 32'(state), 32'd3);
    send("miss2", 16'd300, 1'b0, 16'd90);
    chk("miss2_st", 32'(state), 32'd3);
    send("miss3", 16'd300, 1'b0, 16'd90);
    chk("miss3_st", 32'(state), 32'd1);
    chk("miss3_clear", 32'(prio_clear), 32'd1);
    chk("miss3_relock", 32'(relock_count), 32'd1);
    prio_locked = 1'b0;
    tick();
    chk("miss_acq", 32'(state), 32'd2);
    chk("miss_locked", 32'(locked), 32'd0);
    chk("miss_rate_hold", 32'(rate), 32'd101);
    prio_locked = 1'b1;
    tick();
    chk("miss_retrack", 32'(state), 32'd3);
    tick();
    chk("miss_relocked", 32'(locked), 32'd1);

    // Miss limit zero: never relock.
    miss_limit = 4'd0;
    for (int i = 0; i < 20; i++) send("nolimit", 16'd300, 1'b0, 16'd90);
    chk("nolimit_st", 32'(state), 32'd3);
    chk("nolimit_relock", 32'(relock_count), 32'd1);

    // Timeout from TRACK.
    timeout = 20'd500;
    send("tmo_ref", 16'd100, 1'b1, 16'd100);
    ticks(499);
    chk("tmo_pre", 32'(state), 32'd3);
    tick();
    chk("tmo_clear", 32'(state), 32'd1);
    chk("tmo_relock", 32'(relock_count), 32'd2);
    tick();
    chk("tmo_acq", 32'(state), 32'd2);
    tick();
    chk("tmo_track", 32'(state), 32'd3);

    // Sample landing on the timeout cycle restarts the timer.
    send("tmo_ref2", 16'd100, 1'b1, 16'd100);
    ticks(499);
    send("tmo_race", 16'd100, 1'b1, 16'd100);
    chk("tmo_race_st", 32'(state), 32'd3);
    chk("tmo_race_relock", 32'(relock_count), 32'd2);
    ticks(499);
    chk("tmo_restart_pre", 32'(state), 32'd3);
    tick();
    chk("tmo_restart_clear", 32'(state), 32'd1);
    chk("tmo_restart_relock", 32'(relock_count), 32'd3);

    // Lock loss drops back to ACQUIRE without a relock.
    ticks(2);
    chk("ll_track", 32'(state), 32'd3);
    prio_rate = 16'd105;
    tick();
    chk("ll_locked", 32'(locked), 32'd1);
    chk("ll_rate", 32'(rate), 32'd105);
    prio_locked = 1'b0;
    prio_rate   = 16'd77;
    tick();
    chk("ll_acq", 32'(state), 32'd2);
    chk("ll_unlocked", 32'(locked), 32'd0);
    chk("ll_rate_hold", 32'(rate), 32'd105);
    chk("ll_relock", 32'(relock_count), 32'd3);

    // Disable mid-ACQUIRE overrides a coincident full-rate sample.
    enable = 1'b0;
    send("dis", 16'd100, 1'b0, 16'd100);
    chk("dis_idle", 32'(state), 32'd0);
    chk("dis_clear", 32'(prio_clear), 32'd1);
    tick();
    chk("dis_we", 32'(prio_we), 32'd0);
    chk("dis_rate_hold", 32'(rate), 32'd105);

    // Relock counter saturation.
    miss_limit  = 4'd1;
    timeout     = 20'd0;
    prio_locked = 1'b1;
    enable      = 1'b1;
    ticks(3);
    chk("sat_track", 32'(state), 32'd3);
    for (int i = 0; i < 300; i++) begin
      sample_valid = 1'b1;
      sample       = 16'd300;
      tick();
      sample_valid = 1'b0;
      ticks(2);
    end
    chk("sat_relock", 32'(relock_count), 32'd255);
    chk("sat_st", 32'(state), 32'd3);
    prio_rate = 16'd150;
    tick();
    chk("sat_locked", 32'(locked), 32'd1);
    chk("sat_rate", 32'(rate), 32'd150);

    // Synchronous reset mid-operation.
    rst = 1'b1;
    tick();
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_relock", 32'(relock_count), 32'd0);
    chk("rst2_we", 32'(prio_we), 32'd0);
    chk("rst2_data", 32'(prio_data), 32'd0);
    chk("rst2_locked", 32'(locked), 32'd0);
    chk("rst2_rate", 32'(rate), 32'd0);
    chk("rst2_clear", 32'(prio_clear), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
